// File: rtl/entropy_collector.sv
// Entropy word collector: gathers NUM_WORDS 32-bit words from a syn/ack source into one block
// and hands it to the mixer over valid/ack. Define ENTROPY_COLLECTOR_REPCOUNT_EN for the repetition test.
module entropy_collector #(
  parameter int NUM_WORDS = 16,
  parameter int REP_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           entropy_syn,
  input  logic [31:0]                    entropy_data,
  output logic                           entropy_ack,
  output logic                           block_valid,
  output logic [NUM_WORDS*32-1:0]        block_data,
  input  logic                           block_ack,
  output logic [$clog2(NUM_WORDS+1)-1:0] word_count,
  output logic [31:0]                    blocks_delivered,
  output logic                           health_error
);
  localparam int W  = NUM_WORDS * 32;
  localparam int CW = $clog2(NUM_WORDS + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_FULL    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  if (NUM_WORDS < 2 || NUM_WORDS > 64 || REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_param_check
    $error("entropy_collector: NUM_WORDS or REP_LIMIT out of range");
  end

  logic [2:0]    r_state;
  logic [W-1:0]  r_block;
  logic [CW-1:0] r_wcnt;
  logic [31:0]   r_blocks;
  logic          r_ack;
  logic          r_valid;
  logic          w_health;

`ifdef ENTROPY_COLLECTOR_REPCOUNT_EN
  logic        w_capture;
  logic [31:0] r_prev;
  logic [7:0]  r_rep_cnt;
  logic [7:0]  w_rep_next;
  logic        r_health;

  assign w_capture = enable && (r_state == S_COLLECT) && entropy_syn;

  // A zero count marks "no word since IDLE/reset", so the first capture never counts as a repeat.
  always_comb begin
    w_rep_next = 8'd1;
    if (r_rep_cnt != 8'd0 && entropy_data == r_prev)
      w_rep_next = r_rep_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_rep_cnt <= '0;
      r_health  <= 1'b0;
    end else if (!enable) begin
      r_prev    <= '0;
      r_rep_cnt <= '0;
      r_health  <= 1'b0;
    end else if (w_capture) begin
      r_prev    <= entropy_data;
      r_rep_cnt <= w_rep_next;
      if (w_rep_next == 8'(REP_LIMIT))
        r_health <= 1'b1;
    end
  end

  assign w_health = r_health;
`else
  assign w_health = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_block  <= '0;
      r_wcnt   <= '0;
      r_blocks <= '0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (!enable) begin
        // Abort: partial or unacked block is dropped, delivered count kept.
        r_state <= S_IDLE;
        r_block <= '0;
        r_wcnt  <= '0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_COLLECT;
          S_COLLECT: begin
            if (entropy_syn) begin
              r_block <= {r_block[W-33:0], entropy_data};
              r_wcnt  <= r_wcnt + CW'(1);
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end
          end
          S_ACK: begin
            if (w_health) begin
              r_wcnt  <= '0;
              r_state <= S_ERROR;
            end else if (r_wcnt == CW'(NUM_WORDS)) begin
              r_valid <= 1'b1;
              r_state <= S_FULL;
            end else begin
              r_state <= S_COLLECT;
            end
          end
          S_FULL: begin
            if (block_ack) begin
              r_valid  <= 1'b0;
              r_wcnt   <= '0;
              r_blocks <= r_blocks + 32'd1;
              r_state  <= S_COLLECT;
            end
          end
          S_ERROR: r_wcnt <= '0;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign entropy_ack      = r_ack;
  assign block_valid      = r_valid;
  assign block_data       = r_block;
  assign word_count       = r_wcnt;
  assign blocks_delivered = r_blocks;
  assign health_error     = w_health;
endmodule

// File: tb/tb_entropy_collector.sv
// Scoreboard bench for entropy_collector: stimulus queues expected blocks, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_entropy_collector;
  localparam int NW = 16;
  localparam int W  = NW * 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          entropy_syn = 1'b0;
  logic [31:0]   entropy_data = '0;
  logic          block_ack = 1'b0;
  logic          entropy_ack;
  logic          block_valid;
  logic [W-1:0]  block_data;
  logic [4:0]    word_count;
  logic [31:0]   blocks_delivered;
  logic          health_error;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   data_inc = 32'd1;
  logic [W-1:0]  exp_q[$];
  logic          prev_valid = 1'b0;
  logic          prev_ack = 1'b0;

  entropy_collector #(.NUM_WORDS(NW), .REP_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .entropy_syn(entropy_syn), .entropy_data(entropy_data), .entropy_ack(entropy_ack),
    .block_valid(block_valid), .block_data(block_data), .block_ack(block_ack),
    .word_count(word_count), .blocks_delivered(blocks_delivered), .health_error(health_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_block(input logic [31:0] first, input logic [31:0] step);
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < NW; i++)
      b[W-1-32*i -: 32] = first + step * 32'(i);
    return b;
  endfunction

  // One clock; the source moves to its next word once it sees the ack.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (entropy_ack) entropy_data = entropy_data + data_inc;
  endtask

  task automatic run_acks(input int target, output int got);
    int n;
    n = 0;
    got = 0;
    while (got < target && n < 100) begin
      cyc();
      n++;
      if (entropy_ack) got++;
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!block_valid && n < 100) begin
      cyc();
      n++;
    end
    chk(nm, W'(block_valid), W'(1));
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (entropy_ack) chk("ack_width", W'(prev_ack), '0);
      if (block_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_block", W'(block_valid), '0);
        else chk("block_data", block_data, exp_q.pop_front());
      end
      prev_valid = block_valid;
      prev_ack   = entropy_ack;
    end
  end

  initial begin
    int nack, bad, vcyc, chg, got, nvalid;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", W'(entropy_ack), '0);
    chk("rst_valid", W'(block_valid), '0);
    chk("rst_data", block_data, '0);
    chk("rst_wcnt", W'(word_count), '0);
    chk("rst_blocks", W'(blocks_delivered), '0);
    chk("rst_health", W'(health_error), '0);
    reset_n = 1'b1;
    cyc();

    // Syn held high, incrementing data: acks on odd cycles, valid at cycle 32.
    entropy_data = 32'd1; entropy_syn = 1'b1; enable = 1'b1;
    exp_q.push_back(mk_block(32'd1, 32'd1));
    cyc();
    nack = 0; bad = 0; vcyc = -1;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      cyc();
      if (entropy_ack) begin
        nack++;
        if (c % 2 == 0 || c > 31) bad++;
      end
      if (block_valid) vcyc = c;
    end
    chk("t1_acks", W'(nack), W'(16));
    chk("t1_ack_spacing", W'(bad), '0);
    chk("t1_valid_cycle", W'(vcyc), W'(32));
    chk("t1_wcnt", W'(word_count), W'(16));

    // Mixer stalls 10 cycles while the source keeps syn high.
    nack = 0; chg = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (entropy_ack) nack++;
      if (block_data !== mk_block(32'd1, 32'd1)) chg++;
    end
    chk("t2_no_acks", W'(nack), '0);
    chk("t2_data_stable", W'(chg), '0);
    chk("t2_valid_held", W'(block_valid), W'(1));
    block_ack = 1'b1;
    cyc();
    block_ack = 1'b0; entropy_syn = 1'b0;
    chk("t2_valid_drop", W'(block_valid), '0);
    chk("t2_blocks", W'(blocks_delivered), W'(1));
    chk("t2_wcnt", W'(word_count), '0);

    // Abort after 5 words, then a fresh block.
    entropy_syn = 1'b1;
    run_acks(5, got);
    chk("t3_acks", W'(got), W'(5));
    chk("t3_wcnt5", W'(word_count), W'(5));
    enable = 1'b0; entropy_syn = 1'b0;
    cyc();
    chk("t3_abort_wcnt", W'(word_count), '0);
    chk("t3_abort_data", block_data, '0);
    chk("t3_abort_blocks", W'(blocks_delivered), W'(1));
    chk("t3_abort_valid", W'(block_valid), '0);
    cyc();
    entropy_data = 32'h100; enable = 1'b1; entropy_syn = 1'b1;
    exp_q.push_back(mk_block(32'h100, 32'd1));
    run_acks(1, got);
    chk("t3_restart_wcnt", W'(word_count), W'(1));
    wait_valid("t3_valid");
    block_ack = 1'b1; entropy_syn = 1'b0;
    cyc();
    block_ack = 1'b0;
    chk("t3_blocks", W'(blocks_delivered), W'(2));

    // Constant data: repetition test behaviour.
    data_inc = 32'd0; entropy_data = 32'h01020304; entropy_syn = 1'b1;
`ifdef ENTROPY_COLLECTOR_REPCOUNT_EN
    run_acks(3, got);
    chk("t4_health_pre", W'(health_error), '0);
    run_acks(1, got);
    chk("t4_ack4", W'(entropy_ack), W'(1));
    chk("t4_health", W'(health_error), W'(1));
    nack = 0; nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (entropy_ack) nack++;
      if (block_valid) nvalid++;
    end
    chk("t4_err_acks", W'(nack), '0);
    chk("t4_err_valid", W'(nvalid), '0);
    chk("t4_err_wcnt", W'(word_count), '0);
    chk("t4_err_sticky", W'(health_error), W'(1));
    enable = 1'b0; entropy_syn = 1'b0;
    cyc();
    chk("t4_health_clr", W'(health_error), '0);
    chk("t4_blocks", W'(blocks_delivered), W'(2));
`else
    exp_q.push_back(mk_block(32'h01020304, 32'd0));
    nvalid = 0;
    for (int c = 0; c < 100 && !block_valid; c++) begin
      cyc();
      if (health_error) nvalid++;
    end
    chk("t4_valid", W'(block_valid), W'(1));
    chk("t4_health_never", W'(nvalid), '0);
    block_ack = 1'b1; entropy_syn = 1'b0;
    cyc();
    block_ack = 1'b0;
    chk("t4_blocks", W'(blocks_delivered), W'(3));
    enable = 1'b0;
    cyc();
`endif

    // Reset during ACK of word 7.
    data_inc = 32'd1; entropy_data = 32'h200; enable = 1'b1; entropy_syn = 1'b1;
    cyc();
    run_acks(7, got);
    chk("t5_acks", W'(got), W'(7));
    chk("t5_ack_hi", W'(entropy_ack), W'(1));
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ack", W'(entropy_ack), '0);
    chk("t5_rst_wcnt", W'(word_count), '0);
    chk("t5_rst_data", block_data, '0);
    chk("t5_rst_blocks", W'(blocks_delivered), '0);
    chk("t5_rst_valid", W'(block_valid), '0);
    #2;
    reset_n = 1'b1;
    exp_q.push_back(mk_block(entropy_data, 32'd1));
    run_acks(1, got);
    chk("t5_restart_wcnt", W'(word_count), W'(1));
    wait_valid("t5_valid");
    cyc();
    chk("t5_queue_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/entropy_collector.md
# entropy_collector

Consumer stage on the entropy source's syn/ack word interface. It accepts 32-bit entropy words one at a time and assembles NUM_WORDS of them into one block. It presents the block to the downstream mixer with a valid/ack handshake. It also counts delivered blocks and can optionally run a repetition-count health test on incoming words.

## Interface
Parameters:
- NUM_WORDS, 16: words per block; block width is NUM_WORDS*32 (512 by default). Legal range 2..64.
- REP_LIMIT, 4: number of consecutive identical words that trips the health test. Legal range 2..255. Used only with the macro.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  collector enable; low aborts any operation.
- entropy_syn  in  1  source has a valid word on entropy_data.
- entropy_data  in  32  entropy word from the source.
- entropy_ack  out  1  one-cycle pulse: word consumed.
- block_valid  out  1  block_data holds a complete block.
- block_data  out  NUM_WORDS*32  assembled block. First captured word is in the MSBs, last in the LSBs.
- block_ack  in  1  mixer has taken the block.
- word_count  out  clog2(NUM_WORDS+1)  words in the current partial block.
- blocks_delivered  out  32  count of acked blocks; wraps at 2^32.
- health_error  out  1  sticky repetition-test failure.

## Operation
- States: IDLE, COLLECT, ACK, FULL, ERROR. All are registered.
- **IDLE**
  - If enable=1, move to COLLECT.
- **COLLECT**
  - If entropy_syn=1, the next edge does three things:
    - shifts entropy_data into block_data: block_data <= {block_data[W-33:0], entropy_data};
    - increments word_count;
    - moves to ACK.
- **ACK**
  - entropy_ack=1 for exactly this cycle. entropy_syn is ignored in this cycle.
  - On the next edge:
    - health_error=1: go to ERROR;
    - word_count==NUM_WORDS: go to FULL;
    - otherwise: go to COLLECT.
- **FULL**
  - block_valid=1 and block_data is stable. entropy_syn is not acked.
  - If block_ack=1, the next edge:
    - clears word_count to 0;
    - increments blocks_delivered;
    - moves to COLLECT.
- **ERROR**
  - block_valid=0, no acks, word_count cleared to 0.
  - Leave only via enable=0 (to IDLE), which also clears health_error.
- **enable=0 in any state except IDLE**
  - The next edge goes to IDLE, clears word_count and block_data, and drops block_valid.
  - A partial or unacked block is discarded and blocks_delivered is unchanged.
  - enable=0 takes priority over a simultaneous entropy_syn or block_ack.
- **Source rule:** entropy_data is sampled only on the COLLECT edge where entropy_syn=1. A source holding syn high continuously still yields one word per two cycles.
- blocks_delivered is not cleared by enable; only reset clears it.

## Timing
- Reset values:
  - state IDLE;
  - entropy_ack 0, block_valid 0, block_data 0;
  - word_count 0, blocks_delivered 0, health_error 0;
  - repetition counter 0, previous-word register 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Word throughput: at most 1 word per 2 cycles.
- Block latency with syn held high: if cycle 0 is the first COLLECT cycle with syn=1, the last word is acked in cycle 2*NUM_WORDS-1 and block_valid rises in cycle 2*NUM_WORDS (32 by default).
- block_valid falls in the cycle after block_ack is sampled high. The next capture can occur on that same edge's following COLLECT cycle.
- Reset asserted mid-operation returns immediately to the reset values, including mid-ACK: entropy_ack drops at once.

## Configuration
- Macro: ENTROPY_COLLECTOR_REPCOUNT_EN.
- **Defined:**
  - Every captured word is compared with the previous captured word. The first word after IDLE or reset is never treated as a repeat.
  - Equal: the repeat counter increments. Different: the counter resets to 1.
  - When the counter reaches REP_LIMIT on a capture edge, health_error is set on that same edge. The ACK for that word still completes, then the FSM enters ERROR.
- **Not defined:**
  - No comparison logic or previous-word register is built.
  - health_error is tied to 0 and the ERROR state is unreachable.

## Test plan
- Reset, then enable=1 with syn held high and data incrementing 0x00000001..0x00000010 (NUM_WORDS=16):
  - 16 ack pulses, each 1 cycle, spaced 2 cycles apart;
  - block_valid rises in cycle 32;
  - block_data = 0x00000001_00000002_…_00000010.
- Block complete, block_ack held low for 10 cycles with syn high:
  - no acks, block_data stable;
  - block_ack=1 → block_valid drops next cycle, blocks_delivered=1, word_count=0.
- enable dropped after 5 words captured:
  - next cycle IDLE, word_count=0, block_data=0, blocks_delivered unchanged;
  - on re-enable, a fresh block starts from word 1.
- Macro defined, REP_LIMIT=4, constant data 0x01020304:
  - health_error rises on the 4th capture edge, that word's ack still issued;
  - then ERROR: no further acks, block_valid stays 0;
  - enable low clears health_error.
- Macro undefined, same constant data: full block delivered, health_error stays 0.
- Reset asserted during ACK of word 7: entropy_ack and all outputs go to 0 immediately; after release, collection restarts at word_count=0.
